// File: rtl/fold_incdec_pipe.sv
// One-stage valid/ready pipeline that folds, increments, decrements or
// saturates a WIDTH-bit word and counts every accepted input word.
module fold_incdec_pipe #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] MODE_FOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_SAT  = 2'b11;

  localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ALL_ONES_W = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

  // Packs {flag, result} for one operand/mode pair.
  function automatic logic [WIDTH:0] compute_result(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    logic             f;
    r = ZERO_W;
    f = 1'b0;
    case (m)
      MODE_FOLD: begin
        // Moves the word toward the midpoint, so it can never wrap.
        if (d[WIDTH-1]) begin
          r = d - ONE_W;
        end else begin
          r = d + ONE_W;
        end
        f = 1'b0;
      end
      MODE_INC: begin
        r = d + ONE_W;
        f = (d == ALL_ONES_W);
      end
      MODE_DEC: begin
        r = d - ONE_W;
        f = (d == ZERO_W);
      end
      MODE_SAT: begin
        if (d == ALL_ONES_W) begin
          r = ALL_ONES_W;
          f = 1'b1;
        end else begin
          r = d + ONE_W;
          f = 1'b0;
        end
      end
      default: begin
        r = ZERO_W;
        f = 1'b0;
      end
    endcase
    return {f, r};
  endfunction

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_flag_r;
  logic [CNT_W-1:0] count_r;

  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic [WIDTH:0]   result_s;

  // Handshake decode and next-result computation.
  always_comb begin
    in_ready_s = ~out_valid_r | out_ready;
    in_fire_s  = in_valid & in_ready_s;
    out_fire_s = out_valid_r & out_ready;
    result_s   = compute_result(in_data, in_mode);
  end

  // Output register: load on input transfer, drain on output-only transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= ZERO_W;
      out_flag_r  <= 1'b0;
    end else if (in_fire_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s[WIDTH-1:0];
      out_flag_r  <= result_s[WIDTH];
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_flag_r  <= out_flag_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_flag_r  <= out_flag_r;
    end
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (in_fire_s) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_flag  = out_flag_r;
  assign count     = count_r;

endmodule

// File: tb/tb_fold_incdec_pipe.sv
// Self-checking bench: directed vector table, backpressure/reset sequences,
// a WIDTH=8/CNT_W=2 instance, and random traffic against an arithmetic model.
module tb_fold_incdec_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_flag;
  logic [7:0] count;

  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_in_data;
  logic [1:0] b_in_mode;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_out_data;
  logic       b_out_flag;
  logic [1:0] b_count;

  int checks;
  int failures;

  // Model of the observable state after the most recent edge.
  int m_valid;
  int m_data;
  int m_flag;
  int m_count;

  fold_incdec_pipe #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag),
    .count(count)
  );

  fold_incdec_pipe #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_flag(b_out_flag),
    .count(b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for a 3-bit word, straight from the mode rules.
  function automatic void ref_op(input int d, input int m, output int rd, output int rf);
    case (m)
      0: begin rd = (d >= 4) ? d - 1 : d + 1; rf = 0; end
      1: begin rd = (d + 1) % 8; rf = (d == 7) ? 1 : 0; end
      2: begin rd = (d + 7) % 8; rf = (d == 0) ? 1 : 0; end
      default: begin rd = (d == 7) ? 7 : d + 1; rf = (d == 7) ? 1 : 0; end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_flag = 0; m_count = 0;
  endtask

  // One cycle starting at a falling edge: drive, check in_ready, clock, compare.
  task automatic cycle(input logic iv, input int d, input int m, input logic ordy);
    int rd, rf, exp_ready;
    bit in_fire, out_fire;
    in_valid  = iv;
    in_data   = 3'(d);
    in_mode   = 2'(m);
    out_ready = ordy;
    #1;
    exp_ready = (m_valid == 0 || ordy) ? 1 : 0;
    chk("in_ready", int'(in_ready), exp_ready);
    in_fire  = iv && (exp_ready == 1);
    out_fire = (m_valid == 1) && ordy;
    @(posedge clk);
    if (in_fire) begin
      ref_op(d, m, rd, rf);
      m_valid = 1; m_data = rd; m_flag = rf;
      m_count = (m_count + 1) % 256;
    end else if (out_fire) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", int'(out_valid), m_valid);
    chk("count", int'(count), m_count);
    if (m_valid == 1) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_flag", int'(out_flag), m_flag);
    end
  endtask

  typedef struct {
    int mode;
    int din;
    int dout;
    int flag;
  } vec_t;

  vec_t vecs[12];

  initial begin
    checks = 0;
    failures = 0;
    vecs[0]  = '{0, 0, 1, 0};
    vecs[1]  = '{0, 1, 2, 0};
    vecs[2]  = '{0, 2, 3, 0};
    vecs[3]  = '{0, 3, 4, 0};
    vecs[4]  = '{0, 4, 3, 0};
    vecs[5]  = '{0, 5, 4, 0};
    vecs[6]  = '{0, 6, 5, 0};
    vecs[7]  = '{0, 7, 6, 0};
    vecs[8]  = '{1, 7, 0, 1};
    vecs[9]  = '{2, 0, 7, 1};
    vecs[10] = '{3, 7, 7, 1};
    vecs[11] = '{3, 6, 7, 0};

    rst = 1'b1;
    in_valid = 1'b0; in_data = 3'd0; in_mode = 2'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_in_mode = 2'd0; b_out_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Fold sweep then boundary vectors, streamed at full rate.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vecs[i].din, vecs[i].mode, 1'b1);
      chk($sformatf("vec%0d_data", i), int'(out_data), vecs[i].dout);
      chk($sformatf("vec%0d_flag", i), int'(out_flag), vecs[i].flag);
      if (i == 7) chk("sweep_count", int'(count), 8);
    end

    // Backpressure: hold result 5 for three cycles.
    cycle(1'b1, 4, 1, 1'b1);
    chk("bp_load", int'(out_data), 5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1, 2, 1'b0);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_hold_data", int'(out_data), 5);
      chk("bp_hold_count", int'(count), 13);
    end
    // Simultaneous drain and accept: mode 01, in 2 -> 3.
    cycle(1'b1, 2, 1, 1'b1);
    chk("simul_valid", int'(out_valid), 1);
    chk("simul_data", int'(out_data), 3);
    chk("simul_count", int'(count), 14);
    cycle(1'b0, 0, 0, 1'b1);
    chk("drain_valid", int'(out_valid), 0);
    cycle(1'b0, 5, 3, 1'b0);
    chk("idle_count", int'(count), 14);

    // Async reset between edges, held across an edge with a word offered.
    cycle(1'b1, 3, 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_flag", int'(out_flag), 0);
    chk("arst_count", int'(count), 0);
    in_valid = 1'b1; in_data = 3'd2; in_mode = 2'd1; out_ready = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("arst_no_take_valid", int'(out_valid), 0);
    chk("arst_no_take_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 6, 2, 1'b1);
    chk("restart_data", int'(out_data), 5);
    chk("restart_count", int'(count), 1);

    // Second instance: count wraps at 4, 8-bit fold of 0x80.
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_mode = 2'd0;
      b_in_data = (i == 4) ? 8'h80 : 8'(i);
      @(posedge clk);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    chk("w8_fold_80", int'(b_out_data), 127);
    chk("w8_flag", int'(b_out_flag), 0);
    chk("cntw2_count", int'(b_count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fold_incdec_pipe.md
FOLD_INCDEC_PIPE -- requirements
Module: fold_incdec_pipe

Interface
REQ-001 Parameter WIDTH, default 3, data word width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 8, width of the accepted-transaction counter; legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer has a word on in_data/in_mode.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  operand word.
REQ-008 in_mode  input  2  operation select, sampled with in_data.
REQ-009 out_valid  output  1  out_data/out_flag hold a valid result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_data  output  WIDTH  registered result.
REQ-012 out_flag  output  1  result wrapped or saturated.
REQ-013 count  output  CNT_W  number of accepted input words, modulo 2^CNT_W.

Function
REQ-014 Input transfer occurs on a rising edge where in_valid=1 and in_ready=1; output transfer occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-015 in_ready shall be combinational: in_ready = ~out_valid | out_ready; there is no other internal storage.
REQ-016 Latency shall be one cycle: a word accepted at edge N shall show out_valid=1 with its result after edge N.
REQ-017 Mode 00, fold: if in_data MSB=0, out_data = in_data+1; if MSB=1, out_data = in_data-1; out_flag=0 for all inputs.
REQ-018 Mode 01, increment with wrap: out_data = (in_data+1) mod 2^WIDTH; out_flag=1 only when in_data is all ones.
REQ-019 Mode 10, decrement with wrap: out_data = (in_data-1) mod 2^WIDTH; out_flag=1 only when in_data=0.
REQ-020 Mode 11, saturating increment: out_data = min(in_data+1, 2^WIDTH-1); out_flag=1 only when in_data is all ones (result held at all ones).
REQ-021 The result and flag shall be computed from the in_data/in_mode values present at the accepting edge and latched into the output register.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_flag and out_valid shall stay unchanged, and in_ready shall be 0.
REQ-023 Simultaneous output and input transfer on the same edge shall replace the result with the new one, and out_valid shall remain 1; full throughput is one word per cycle.
REQ-024 An output transfer with no input transfer shall clear out_valid on that edge; out_data may hold its old value.
REQ-025 count shall increment by 1 on every input transfer, wrapping from 2^CNT_W-1 to 0; it is unaffected by output transfers and by mode.
REQ-026 in_mode and in_data are don't-care when in_valid=0; an idle cycle shall change no state.

Reset
REQ-027 Asserting rst shall immediately, without waiting for a clock edge, set out_valid=0, out_data=0, out_flag=0 and count=0.
REQ-028 While rst=1, in_ready shall be 1 (out_valid=0), but no transfer shall be taken; any result in flight at reset is discarded.
REQ-029 The first rising edge with rst=0 shall behave as a normal cycle.

Verification (WIDTH=3 unless stated)
REQ-030 Fold sweep: mode 00, in_data 0..7 streamed with out_ready=1 -> out_data 1,2,3,4,3,4,5,6 on consecutive cycles; out_flag always 0; count ends at 8.
REQ-031 Boundaries:
- mode 01, in 7 -> out 0, flag 1.
- mode 10, in 0 -> out 7, flag 1.
- mode 11, in 7 -> out 7, flag 1.
- mode 11, in 6 -> out 7, flag 0.
REQ-032 Backpressure: result 5 held with out_ready=0 for 3 cycles and in_valid=1 -> in_ready=0, out_data stays 5, count unchanged; out_ready=1 -> new word accepted on that edge.
REQ-033 Simultaneous: out_valid=1, out_ready=1, in_valid=1 (mode 01, in 2) -> out_valid stays 1, out_data becomes 3 next cycle.
REQ-034 Async reset mid-stream between clock edges -> out_valid, out_data, out_flag and count go to 0 before the next edge; stream restarts cleanly after release.
REQ-035 CNT_W=2, 5 accepted words -> count=1; WIDTH=8, mode 00, in 0x80 -> out 0x7F.
